// File: rtl/le_mbuff_if.sv
// Token types and the lane/link bundle for le_mbuff.
// Forward tokens carry a valid bit and a data byte; backward tokens carry nack and t/v/c flags.
package le_mbuff_pkg;
  typedef struct packed {
    logic       v;
    logic [7:0] data;
  } FTk_t;

  typedef struct packed {
    logic n;
    logic t;
    logic v;
    logic c;
  } BTk_t;
endpackage

interface le_mbuff_if
  import le_mbuff_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DEPTH_FIFO = 16
);
  localparam int unsigned WIDTH_NUM = $clog2(DEPTH_FIFO);
  localparam int unsigned WIDTH_CH  = $clog2(NUM_CH);

  FTk_t [NUM_CH-1:0]               I_FTk;
  BTk_t [NUM_CH-1:0]               O_BTk;
  FTk_t                            O_FTk;
  logic [WIDTH_CH-1:0]             O_Ch;
  BTk_t                            I_BTk;
  logic                            I_Chg_Buff;
  logic                            I_Rls_Buff;
  logic [NUM_CH-1:0]               O_Empty;
  logic [NUM_CH-1:0]               O_Full;
  logic [NUM_CH-1:0]               O_Ovf;
  logic [NUM_CH-1:0][WIDTH_NUM:0]  O_Num;

  modport master (
    output I_FTk, I_BTk, I_Chg_Buff, I_Rls_Buff,
    input  O_BTk, O_FTk, O_Ch, O_Empty, O_Full, O_Ovf, O_Num
  );

  modport slave (
    input  I_FTk, I_BTk, I_Chg_Buff, I_Rls_Buff,
    output O_BTk, O_FTk, O_Ch, O_Empty, O_Full, O_Ovf, O_Num
  );
endinterface

// File: rtl/le_mbuff.sv
// Multi-lane LE buffer: per-lane ring FIFOs merged onto one link by round-robin arbitration.
// Define LE_MBUFF_BYPASS_EN to forward a token from an empty lane in the same cycle.
module le_mbuff
  import le_mbuff_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DEPTH_FIFO = 16,
  parameter int unsigned THRESHOLD  = 4,
  parameter int unsigned HEADROOM   = 3
) (
  input logic       clock,
  input logic       reset,
  le_mbuff_if.slave bus
);
  localparam int unsigned WIDTH_NUM = $clog2(DEPTH_FIFO);
  localparam int unsigned WIDTH_CH  = $clog2(NUM_CH);
  localparam int unsigned NW        = WIDTH_NUM + 1;

  localparam logic [WIDTH_NUM:0] NumMax = NW'(DEPTH_FIFO);
  localparam logic [WIDTH_NUM:0] HiMark = NW'(DEPTH_FIFO - HEADROOM);
  localparam logic [WIDTH_NUM:0] LoMark = NW'(THRESHOLD);

`ifdef LE_MBUFF_BYPASS_EN
  localparam bit BypassEn = 1'b1;
`else
  localparam bit BypassEn = 1'b0;
`endif

  FTk_t                           mem_q [NUM_CH][DEPTH_FIFO];
  logic [NUM_CH-1:0][WIDTH_NUM-1:0] wr_ptr_q, rd_ptr_q;
  logic [NUM_CH-1:0][WIDTH_NUM:0]   num_q, num_d;
  logic [NUM_CH-1:0]              full_q, full_d;
  logic [NUM_CH-1:0]              ovf_q, ovf_d;
  logic [WIDTH_CH-1:0]            rr_ptr_q, rr_ptr_d;

  logic                hold, send, grant_vld;
  logic [WIDTH_CH-1:0] grant;
  int unsigned         idx;
  logic [NUM_CH-1:0]   cand, sel, pop, byp, push, drop;

  // Arbitration, pop/bypass/push decisions and next state.
  always_comb begin
    hold = bus.I_Chg_Buff & ~bus.I_Rls_Buff;
    // Gating with reset keeps a bypass-eligible input from reaching O_FTk while in reset.
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      cand[c] = ~reset & ((num_q[c] != '0) | (BypassEn & bus.I_FTk[c].v));
    end

    grant_vld = 1'b0;
    grant     = '0;
    idx       = 0;
    for (int unsigned off = 0; off < NUM_CH; off++) begin
      idx = 32'(rr_ptr_q) + off;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!grant_vld && cand[WIDTH_CH'(idx)]) begin
        grant_vld = 1'b1;
        grant     = WIDTH_CH'(idx);
      end
    end

    send = grant_vld & ~hold & ~bus.I_BTk.n;

    for (int unsigned c = 0; c < NUM_CH; c++) begin
      sel[c]  = send & (grant == WIDTH_CH'(c));
      pop[c]  = sel[c] & (num_q[c] != '0);
      byp[c]  = sel[c] & (num_q[c] == '0);
      push[c] = bus.I_FTk[c].v & ~byp[c] & ((num_q[c] != NumMax) | pop[c]);
      drop[c] = bus.I_FTk[c].v & ~byp[c] & (num_q[c] == NumMax) & ~pop[c];
      num_d[c] = num_q[c] + NW'(push[c]) - NW'(pop[c]);
      ovf_d[c] = ovf_q[c] | drop[c];
      // Hysteresis on registered occupancy: high mark sets, low mark clears.
      if (num_q[c] >= HiMark)     full_d[c] = 1'b1;
      else if (num_q[c] < LoMark) full_d[c] = 1'b0;
      else                        full_d[c] = full_q[c];
    end

    rr_ptr_d = rr_ptr_q;
    if (send) rr_ptr_d = (32'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;
  end

  always_comb begin
    bus.O_FTk = '0;
    bus.O_Ch  = '0;
    if (send) begin
      bus.O_FTk = pop[grant] ? mem_q[grant][rd_ptr_q[grant]] : bus.I_FTk[grant];
      bus.O_Ch  = grant;
    end
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      bus.O_BTk[c]   = '0;
      bus.O_BTk[c].n = full_q[c] | (bus.I_BTk.n & grant_vld & (grant == WIDTH_CH'(c)));
      if (sel[c]) begin
        bus.O_BTk[c].t = bus.I_BTk.t;
        bus.O_BTk[c].v = bus.I_BTk.v;
        bus.O_BTk[c].c = bus.I_BTk.c;
      end
      bus.O_Empty[c] = (num_q[c] == '0);
    end
    bus.O_Full = full_q;
    bus.O_Ovf  = ovf_q;
    bus.O_Num  = num_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      num_q    <= '0;
      full_q   <= '0;
      ovf_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= wr_ptr_q[c] + WIDTH_NUM'(push[c]);
        rd_ptr_q[c] <= rd_ptr_q[c] + WIDTH_NUM'(pop[c]);
      end
      num_q    <= num_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Storage needs no reset; stale entries are never visible once the pointers clear.
  always_ff @(posedge clock) begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (push[c]) mem_q[c][wr_ptr_q[c]] <= bus.I_FTk[c];
    end
  end
endmodule
